// File: rtl/reg_file_32x32_pkg.sv
// Shared definitions for the general-purpose register file.
//   REG_ADDR_W / REG_DATA_W : default address and data widths
//   REG_ZERO / REG_SP / REG_RA : named register indices (REG_RA is the
//                                jal link-register writeback target)
package reg_file_32x32_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_SP   = 5'd29;
    localparam logic [REG_ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/reg_file_32x32_read_port.sv
// reg_read_port: one combinational read mux over the register array.
//   rst   : reset level. While it is high, the bypass path is suppressed so
//           the port reads the (cleared) array.
//   regs  : whole storage array, packed by register index.
//   raddr : read address.
//   rdata : read data. Address 0 always reads 0.
//   we / waddr / wdata : the current write request, used only when BYPASS=1
//           for write-first forwarding.
module reg_read_port
    import reg_file_32x32_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic                                 rst,
    input  logic [2**ADDR_W-1:0][DATA_W-1:0]     regs,
    input  logic [ADDR_W-1:0]                    raddr,
    input  logic                                 we,
    input  logic [ADDR_W-1:0]                    waddr,
    input  logic [DATA_W-1:0]                    wdata,
    output logic [DATA_W-1:0]                    rdata
);

    always_comb begin
        rdata = regs[raddr];
        // Write-first forwarding; rst blocks the write, so it blocks this too.
        if (BYPASS != 0 && we && !rst && waddr == raddr)
            rdata = wdata;
        // Register 0 wins over everything, bypass included.
        if (raddr == ADDR_W'(REG_ZERO))
            rdata = '0;
    end

endmodule

// File: rtl/reg_file_32x32.sv
// reg_file_32x32: 32 x DATA_W general-purpose register file.
//   clk, rst          : clock (rising edge) and async active-high reset.
//   raddr1/rdata1     : read port 1 (ALU operand a), combinational.
//   raddr2/rdata2     : read port 2 (ALU operand b / store data), combinational.
//   we/waddr/wdata    : one synchronous write per cycle; address 0 dropped.
//   dbg_addr/dbg_data : read-only debug port, never bypassed.
// BYPASS must be 0 in the single-cycle datapath: wdata is a combinational
// function of rdata through the ALU, so forwarding would form a loop.
module reg_file_32x32
    import reg_file_32x32_pkg::*;
#(
    parameter int DATA_W = REG_DATA_W,
    parameter int ADDR_W = REG_ADDR_W,
    parameter int BYPASS = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);

    localparam int DEPTH  = 2**ADDR_W;
    localparam int NUM_RD = 2;

    logic [DEPTH-1:0][DATA_W-1:0]  regs;
    logic [NUM_RD-1:0][ADDR_W-1:0] raddr_v;
    logic [NUM_RD-1:0][DATA_W-1:0] rdata_v;

    // Storage and write. Entry 0 is never written, so it stays 0 from reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            regs <= '0;
        else if (we && waddr != ADDR_W'(REG_ZERO))
            regs[waddr] <= wdata;
    end

    assign raddr_v = {raddr2, raddr1};
    assign rdata1  = rdata_v[0];
    assign rdata2  = rdata_v[1];

    // Datapath read ports share the bypass setting.
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        reg_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W),
            .BYPASS (BYPASS)
        ) u_port (
            .rst   (rst),
            .regs  (regs),
            .raddr (raddr_v[p]),
            .we    (we),
            .waddr (waddr),
            .wdata (wdata),
            .rdata (rdata_v[p])
        );
    end

    // Debug port shows committed state only.
    reg_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (0)
    ) u_dbg_port (
        .rst   (rst),
        .regs  (regs),
        .raddr (dbg_addr),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .rdata (dbg_data)
    );

endmodule

// File: doc/reg_file_32x32.md
Name: reg_file_32x32

Overview:
- General-purpose register file for the single-cycle CPU.
- Sits directly upstream of the ALU: its two read ports drive ALU operands a and b, which feed the per-bit logic units (AND/OR/etc.).
- Accepts one synchronous write per cycle from the writeback mux.
- Provides an extra read-only debug port for board display.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, register address width; depth = 2**ADDR_W = 32.
- BYPASS, 0, 1 = a same-cycle write is forwarded to the matching read port; 0 = reads return the pre-write value.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous reset, active-high.
- raddr1  input  ADDR_W  read port 1 address (rs).
- raddr2  input  ADDR_W  read port 2 address (rt).
- rdata1  output  DATA_W  read port 1 data, to ALU operand a.
- rdata2  output  DATA_W  read port 2 data, to ALU operand b / store data.
- we  input  1  write enable.
- waddr  input  ADDR_W  write address (rd/rt from the destination mux).
- wdata  input  DATA_W  write data from the writeback mux.
- dbg_addr  input  ADDR_W  debug read address.
- dbg_data  output  DATA_W  debug read data.

Behaviour:
- Interface: one clock, clk. rst is asynchronous and active-high.
- Storage: 32 x DATA_W flops, regs[0..31].
- Reset:
  - rst high clears every register to 0 immediately, without waiting for a clock edge.
  - rdata1, rdata2 and dbg_data read 0 while rst is high.
  - Writes are blocked while rst is high.
  - On rst deassertion, the first write takes effect at the first rising clk edge after release.
- Write:
  - On rising clk with we=1, rst=0 and waddr!=0: regs[waddr] <= wdata.
  - Write latency is 1 cycle; the new value is visible on the read ports after that edge.
- Register 0:
  - Hardwired to 0. Writes to address 0 are silently dropped.
  - Reads of address 0 return 0 on every port, regardless of BYPASS.
- Read:
  - Fully combinational (0-cycle latency), as required by the single-cycle datapath.
  - rdataN = regs[raddrN].
  - raddr1 == raddr2 is legal; both ports return the same value.
- Bypass:
  - When BYPASS=1, we=1, waddr!=0 and raddrN==waddr, rdataN = wdata (write-first).
  - The debug port never bypasses.
  - BYPASS must stay 0 in the single-cycle CPU: wdata derives combinationally from rdata via the ALU, so bypass would close a combinational loop.
  - BYPASS=1 is reserved for a future pipelined datapath.
- Simultaneous events:
  - A write and a read of the same register in one cycle with BYPASS=0 returns the old value until the edge.
  - rst asserted during a write cycle: reset wins and the register ends at 0.
- No X propagation: all registers are defined from reset onward.

Decomposition:
- Shared package/header holds:
  - REG_ADDR_W = 5 and REG_DATA_W = 32.
  - Named register indices: REG_ZERO = 0, REG_SP = 29, REG_RA = 31, used by the control unit for jal writeback.
- Sub-module: reg_read_port, one combinational read mux including the zero-register and optional bypass logic.
  - Instantiated three times: rdata1, rdata2 and debug (debug with bypass tied off).
- The storage array and write logic stay in the top module.

Test Plan:
1. Reset: preload regs[5]=32'h1234_5678, then assert rst mid-cycle with no clk edge → rdata1 with raddr1=5 reads 32'h0 immediately; all 32 registers read 0 after release.
2. Write/read: we=1, waddr=8, wdata=32'hDEAD_BEEF at edge N.
   - raddr1=8 reads the old value (0) before edge N.
   - It reads 32'hDEAD_BEEF after edge N.
   - dbg_addr=8 matches.
3. Register 0: we=1, waddr=0, wdata=32'hFFFF_FFFF → raddr1=raddr2=0 read 32'h0 on all later cycles.
4. Dual read / same address: regs[3]=32'hA5A5_A5A5, regs[4]=32'h5A5A_5A5A.
   - raddr1=3, raddr2=4 → both values together.
   - raddr1=raddr2=3 → both ports 32'hA5A5_A5A5.
5. Bypass (BYPASS=1 build): regs[9]=1; in the same cycle we=1, waddr=9, wdata=2, raddr1=9.
   - rdata1=2 before the edge.
   - dbg_data (dbg_addr=9) = 1 before the edge.
   - With the BYPASS=0 build, rdata1=1 before the edge.
6. Back-to-back writes to regs[31] with 32'h0000_0010 then 32'h0000_0020 on consecutive edges, with rst pulsed between them asynchronously → final value 32'h0000_0020 only if the write edge follows rst release; otherwise 0.
